// File: rtl/round_sequencer_pkg.sv
// Shared state encoding, stage indices and default sizing for the round sequencer.
// Imported by the interface, the stage watchdog and the sequencer top.
package round_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ISSUE,
        WAIT,
        ADVANCE,
        DONE,
        ERR
    } seq_state_t;

    localparam int STG_COLPAR  = 0;
    localparam int STG_ROTATE  = 1;
    localparam int STG_PERMUTE = 2;
    localparam int STG_REVAL   = 3;
    localparam int STG_ADDRC   = 4;

    localparam int DEF_NUM_ROUNDS = 24;
    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_ROUND_W    = 5;
    localparam int DEF_TIMEOUT    = 1024;

    // Counter width that stays legal when a size parameter is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Stage start/ready bundle plus the encoder-level start/ready/status signals.
// master = sequencer side, slave = encoder top and stage controllers.
interface round_sequencer_if
    import round_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int ROUND_W    = DEF_ROUND_W
);

    logic                  start;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_start;
    logic [ROUND_W-1:0]    round;
    logic                  bank_sel;
    logic                  busy;
    logic                  ready;
    logic                  err;

    modport master (
        input  start,
        input  stage_ready,
        output stage_start,
        output round,
        output bank_sel,
        output busy,
        output ready,
        output err
    );

    modport slave (
        output start,
        output stage_ready,
        input  stage_start,
        input  round,
        input  bank_sel,
        input  busy,
        input  ready,
        input  err
    );

endinterface

// File: rtl/round_sequencer_stage_watchdog.sv
// Per-stage response watchdog: counts enabled cycles from a clear and flags
// expiry on the TIMEOUT-th cycle, then holds without wrapping.
module stage_watchdog
    import round_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Initiator of the stage start/ready handshake: walks every stage of every round
// in order, flips the frame-memory bank after each stage and reports completion.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int ROUND_W    = DEF_ROUND_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic             clk,
    input logic             rst,
    round_sequencer_if.master bus
);

    localparam int                 STAGE_W    = cnt_width(NUM_STAGES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [STAGE_W-1:0]    stage;
    logic [STAGE_W-1:0]    stage_nxt;
    logic [ROUND_W-1:0]    round_q;
    logic [ROUND_W-1:0]    round_nxt;
    logic                  bank_q;
    logic                  bank_nxt;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  own_ready;
    logic                  foreign_ready;
    logic                  wd_expired;

    always_comb begin
        stage_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_onehot[i] = (stage == STAGE_W'(i));
        end
    end

    assign own_ready     = |(bus.stage_ready & stage_onehot);
    assign foreign_ready = |(bus.stage_ready & ~stage_onehot);

    // Timer runs only while waiting on a stage and restarts from zero everywhere else.
    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            stage   <= '0;
            round_q <= '0;
            bank_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            stage   <= stage_nxt;
            round_q <= round_nxt;
            bank_q  <= bank_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        round_nxt = round_q;
        bank_nxt  = bank_q;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = ARM;
            end
            ARM: begin
                if (!bus.start) begin
                    state_nxt = ISSUE;
                    stage_nxt = '0;
                    round_nxt = '0;
                    bank_nxt  = 1'b0;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            // The addressed stage's ready wins over a stray ready or a same-cycle expiry.
            WAIT: begin
                if (own_ready) begin
                    state_nxt = ADVANCE;
                end else if (foreign_ready || wd_expired) begin
                    state_nxt = ERR;
                end
            end
            ADVANCE: begin
                bank_nxt = ~bank_q;
                if (stage != LAST_STAGE) begin
                    stage_nxt = stage + 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    stage_nxt = '0;
                    if (round_q == LAST_ROUND) begin
                        state_nxt = DONE;
                    end else begin
                        round_nxt = round_q + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                if (bus.start) state_nxt = ARM;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.stage_start = (state == ISSUE) ? stage_onehot : '0;
    assign bus.round       = round_q;
    assign bus.bank_sel    = bank_q;
    assign bus.busy        = (state == ISSUE) || (state == WAIT) || (state == ADVANCE);
    assign bus.ready       = (state == DONE);
    assign bus.err         = (state == ERR);

endmodule
